// File: rtl/i2c_pkg.sv
// i2c_pkg: shared state/phase encodings and bus constants for the I2C byte engines.
package i2c_pkg;
  typedef enum logic [1:0] {IDLE, DATA, ACK, DONE} state_t;
  typedef enum logic [1:0] {Q0, Q1, Q2, Q3} phase_t;
  localparam logic I2C_ACK = 1'b0;
  localparam logic I2C_NACK = 1'b1;
  localparam int BITS_PER_BYTE = 8;
endpackage

// File: rtl/i2c_scl_phase_gen.sv
// i2c_scl_phase_gen: SCL quarter-phase sequencer with clock-stretch freeze in Q2.
module i2c_scl_phase_gen
  import i2c_pkg::*;
#(
  parameter int QUARTER = 4
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   en,
  input  logic   scl_in,
  output logic   scl,
  output phase_t phase,
  output logic   last_cycle_of_phase
);
  localparam int CW = QUARTER > 1 ? $clog2(QUARTER) : 1;
  logic [CW-1:0] cnt;
  logic stall;
  // a slave holding SCL low during the high half freezes the counter
  assign stall = phase == Q2 && !scl_in;
  assign last_cycle_of_phase = en && !stall && cnt == CW'(QUARTER - 1);
  assign scl = en && (phase == Q2 || phase == Q3);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      phase <= Q0;
    end else if (!en) begin
      cnt <= '0;
      phase <= Q0;
    end else if (last_cycle_of_phase) begin
      cnt <= '0;
      phase <= phase_t'(phase + 2'd1);
    end else if (!stall) begin
      cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/i2c_master_write_byte.sv
// i2c_master_write_byte: shifts one byte MSB-first onto SDA, then samples the slave ACK.
module i2c_master_write_byte
  import i2c_pkg::*;
#(
  parameter int QUARTER = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       go,
  input  logic [7:0] data_in,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       scl,
  output logic       sda_drive_low,
  output logic       busy,
  output logic       finish,
  output logic       error
);
  state_t state, state_nx;
  phase_t phase;
  logic go_q, last, en, accept, bit_end;
  logic [7:0] shreg;
  logic [3:0] bitcnt;
  assign en = state == DATA || state == ACK;
  assign accept = go && !go_q && state == IDLE;
  assign bit_end = last && phase == Q3;
  i2c_scl_phase_gen #(.QUARTER(QUARTER)) u_phase (
    .clk(clk),
    .rst_n(rst_n),
    .en(en),
    .scl_in(scl_in),
    .scl(scl),
    .phase(phase),
    .last_cycle_of_phase(last)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  end
  always_comb begin
    state_nx = state;
    sda_drive_low = state == DATA && !shreg[7];
    busy = state != IDLE;
    finish = state == DONE;
    case (state)
      IDLE: state_nx = accept ? DATA : IDLE;
      DATA: state_nx = (bit_end && bitcnt == 4'(BITS_PER_BYTE - 1)) ? ACK : DATA;
      ACK: state_nx = bit_end ? DONE : ACK;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      go_q <= 1'b0;
      shreg <= '0;
      bitcnt <= '0;
      error <= 1'b0;
    end else begin
      go_q <= go;
      if (accept) begin
        shreg <= data_in;
        bitcnt <= '0;
        error <= 1'b0;
      end else if (state == DATA && bit_end) begin
        shreg <= {shreg[6:0], 1'b0};
        bitcnt <= bitcnt + 1'b1;
      end
      // ACK is taken at the end of the (possibly stretched) high half
      if (state == ACK && phase == Q2 && last) error <= sda_in == I2C_NACK;
    end
  end
endmodule

// File: tb/tb_i2c_master_write_byte.sv
// tb_i2c_master_write_byte: timeline model of one byte write checked every cycle, plus literal pins.
module tb_i2c_master_write_byte;
  localparam int Q = 4;
  localparam int BT = 4 * Q;
  logic clk = 1'b0, rst_n = 1'b0, go = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic scl_in, sda_in, scl, sda_drive_low, busy, finish, error;
  int cyc = 0, acc_cyc = 0, pass_cnt = 0, chk_cnt = 0, fin_cnt = 0;
  int m_ss = 0, m_sl = 0, t_now;
  logic active = 1'b0, m_nack = 1'b0, hold, pull, scl_prev = 1'b0;
  logic [7:0] m_d = 8'h00;
  logic rises[$];

  i2c_master_write_byte #(.QUARTER(Q)) dut (
    .clk(clk), .rst_n(rst_n), .go(go), .data_in(data_in), .scl_in(scl_in),
    .sda_in(sda_in), .scl(scl), .sda_drive_low(sda_drive_low), .busy(busy),
    .finish(finish), .error(error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // bit time index since acceptance with any stretch window removed
  function automatic int u_of(input int t, input int ss, input int sl);
    int e;
    e = t - 1;
    if (sl == 0 || e < ss) return e;
    if (e < ss + sl) return ss;
    return e - sl;
  endfunction

  assign t_now = cyc - acc_cyc + 1;
  assign hold = active && m_sl > 0 && t_now > m_ss && t_now <= m_ss + m_sl;
  assign pull = active && !m_nack && t_now >= 1 &&
                u_of(t_now, m_ss, m_sl) >= 8 * BT && u_of(t_now, m_ss, m_sl) < 9 * BT;
  assign scl_in = scl & ~hold;
  assign sda_in = ~sda_drive_low & ~pull;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s t=%0d got %0h want %0h", nm, t_now, act, exp);
  endtask

  always @(negedge clk) begin
    int u, b, q;
    logic es, ed, eb, ef, ee;
    if (active && rst_n && t_now >= 1) begin
      u = u_of(t_now, m_ss, m_sl);
      es = 1'b0; ed = 1'b0; eb = 1'b0; ef = 1'b0;
      if (u < 9 * BT) begin
        b = u / BT;
        q = (u % BT) / Q;
        es = q >= 2;
        ed = b < 8 ? ~m_d[7 - b] : 1'b0;
        eb = 1'b1;
      end else if (u == 9 * BT) begin
        eb = 1'b1;
        ef = 1'b1;
      end
      ee = u >= 8 * BT + 3 * Q ? m_nack : 1'b0;
      chk("scl", scl, es);
      chk("sda_drive_low", sda_drive_low, ed);
      chk("busy", busy, eb);
      chk("finish", finish, ef);
      chk("error", error, ee);
      if (scl && !scl_prev && rises.size() < 8) rises.push_back(sda_drive_low);
      if (finish) fin_cnt++;
    end
    scl_prev = scl;
  end

  task automatic start(input logic [7:0] d, input logic nack, input int ss, input int sl);
    @(posedge clk); #2;
    data_in = d; go = 1'b1;
    m_d = d; m_nack = nack; m_ss = ss; m_sl = sl;
    acc_cyc = cyc + 1; active = 1'b1;
    rises.delete(); fin_cnt = 0;
  endtask

  task automatic wait_fin(input int lat);
    int n = 0;
    while (!finish && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("finish_latency", t_now, lat);
  endtask

  task automatic chk_rises(input logic [7:0] exp);
    logic [7:0] r = 8'h00;
    chk("rise_count", rises.size(), 8);
    if (rises.size() == 8) for (int i = 0; i < 8; i++) r[7 - i] = rises[i];
    chk("rise_seq", r, exp);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #2;
    chk("rst_scl", scl, 0); chk("rst_sda", sda_drive_low, 0); chk("rst_busy", busy, 0);
    chk("rst_finish", finish, 0); chk("rst_error", error, 0);
    rst_n = 1'b1;
    start(8'hA5, 1'b0, 0, 0);
    wait_fin(145);
    chk("a5_error", error, 0);
    @(negedge clk);
    chk("a5_busy_drop", busy, 0);
    chk_rises(8'b0101_1010);
    go = 1'b0;
    start(8'h3C, 1'b1, 0, 0);
    wait_fin(145);
    chk("3c_nack", error, 1);
    go = 1'b0;
    repeat (10) @(negedge clk);
    chk("3c_nack_held", error, 1);
    start(8'hFF, 1'b0, 3 * BT + 2 * Q, 20);
    @(negedge clk);
    @(negedge clk);
    chk("err_clear_on_go", error, 0);
    wait_fin(165);
    chk("ff_error", error, 0);
    go = 1'b0;
    start(8'h81, 1'b0, 0, 0);
    repeat (50) @(posedge clk);
    #2;
    chk("pre_rst_sda", sda_drive_low, 1); chk("pre_rst_busy", busy, 1);
    rst_n = 1'b0; active = 1'b0;
    #1;
    chk("mid_rst_scl", scl, 0); chk("mid_rst_sda", sda_drive_low, 0);
    chk("mid_rst_busy", busy, 0); chk("mid_rst_finish", finish, 0);
    go = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;
    start(8'h81, 1'b0, 0, 0);
    wait_fin(145);
    chk("81_error", error, 0);
    repeat (20) @(negedge clk);
    chk("held_go_no_restart", busy, 0);
    chk("held_go_one_finish", fin_cnt, 1);
    @(posedge clk); #2;
    go = 1'b0;
    start(8'h00, 1'b0, 0, 0);
    wait_fin(145);
    chk("00_ack", error, 0);
    @(posedge clk); #2;
    go = 1'b0;
    start(8'hC3, 1'b0, 0, 0);
    repeat (28) @(posedge clk);
    #2;
    go = 1'b0; data_in = 8'h55;
    @(posedge clk); #2;
    go = 1'b1;
    wait_fin(145);
    repeat (5) @(negedge clk);
    chk("busy_go_single_finish", fin_cnt, 1);
    chk_rises(8'b0011_1100);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule

// File: doc/i2c_master_write_byte.md
Name: i2c_master_write_byte

Overview:
Byte-level I2C master transmitter. It is the write-direction counterpart of the byte reader in the controller.
- On a go request it latches an 8-bit byte and shifts it MSB-first onto SDA while generating SCL.
- It then releases SDA for the ACK bit and reports ACK/NACK to the controller FSM.
- It runs only between START/repeated-START and STOP; the top level owns the bus outside byte transfers.

Parameters:
QUARTER, 4, clk cycles per SCL quarter-period (>=1); one bit time = 4*QUARTER cycles.

Ports:
clk  input  1  system clock
rst_n  input  1  reset; asynchronous, active-low
go  input  1  start request; a transfer begins on a 0->1 transition sampled while idle
data_in  input  8  byte to send; latched only in the cycle go is accepted
scl_in  input  1  sampled SCL bus level, used for clock-stretch detection
sda_in  input  1  sampled SDA bus level, used for the ACK bit
scl  output  1  SCL drive level (1 = released/high, 0 = driven low)
sda_drive_low  output  1  1 = pull SDA low; 0 = release SDA (open-drain)
busy  output  1  high from go acceptance until the finish cycle, inclusive
finish  output  1  one-cycle pulse at transfer end
error  output  1  1 = NACK received; valid with finish; held until next go acceptance

Behaviour:
- Reset values (async, immediate, including mid-transfer): scl=0, sda_drive_low=0, busy=0, finish=0, error=0. State returns to IDLE and the go edge detector is cleared.
- go edge detection: a registered copy of go is kept. Acceptance requires go=1 in the current cycle with the registered copy = 0, and state IDLE.
  - go held high across finish does not restart; go must be sampled low for at least one cycle first.
  - go pulses while busy are ignored.
- States: IDLE -> DATA (bits 7..0) -> ACK -> DONE -> IDLE.
- Each bit has 4 quarters of QUARTER cycles:
  - Q0: scl=0; sda_drive_low = ~bit, updated on the first cycle of Q0.
  - Q1: scl=0.
  - Q2: scl=1.
  - Q3: scl=1.
  - SDA never changes while scl=1.
- Clock stretching: while in Q2 with scl=1 and scl_in=0, the quarter counter freezes. It resumes the cycle after scl_in reads 1. No timeout.
- ACK bit: sda_drive_low=0 for all four quarters. sda_in is sampled on the last cycle of Q2 (after any stretch): 0=ACK, 1=NACK. The result is stored to error.
- DONE: one cycle with scl=0, sda_drive_low=0, finish=1, busy=1. Next cycle: IDLE, busy=0.
- Latency, no stretching: go accepted at edge N -> DATA Q0 starts at N+1 -> finish high in cycle N+1+36*QUARTER. QUARTER=4 gives finish 145 cycles after acceptance.
- IDLE: scl=0, sda_drive_low=0, shift register holds its last value.
- The bit counter is 4 bits, 0..8 (8 = ACK); no wrap beyond 8.
- data_in changes after acceptance have no effect.

Decomposition:
- Shared package i2c_pkg:
  - state enum (IDLE, DATA, ACK, DONE).
  - quarter-phase enum (Q0..Q3).
  - constants I2C_ACK=1'b0, I2C_NACK=1'b1, BITS_PER_BYTE=8.
- One natural sub-module, i2c_scl_phase_gen:
  - QUARTER counter and phase register, with the stretch freeze on scl_in.
  - Outputs scl, phase, and last_cycle_of_phase strobes.
  - Reusable by the byte reader.

Test Plan:
- data_in=8'hA5, go rising edge, bus model pulls SDA low in the ACK slot -> at each scl rising edge, sda_drive_low shows the sequence 0,1,0,1,1,0,1,0. Then finish pulses 145 cycles after acceptance, error=0, busy drops the next cycle.
- data_in=8'h3C, no ACK (SDA pulled up) -> finish pulses with error=1; error stays 1 until the next go acceptance, then clears.
- data_in=8'hFF, bus model holds scl_in low for 20 cycles in bit 3 Q2 -> scl=1 throughout, counter frozen. Finish arrives at 165 cycles; SDA is stable whenever scl=1.
- rst_n asserted at cycle 50 of a 8'h81 transfer -> in the same timestep scl=0, sda_drive_low=0, busy=0, with no finish pulse. A fresh go after release completes normally.
- go held high through finish -> no second transfer. go low 1 cycle then high -> a second transfer of the new data_in=8'h00 starts and ACKs.
- go toggled 0->1 at cycle 30 during an active transfer -> ignored; exactly one finish pulse is produced and the latched byte is unchanged.
